// File: rtl/boot_loader_pkg.sv
// boot_loader_pkg: shared state encodings, RAM write-enable codes and default image offsets.
//   BOOT_* states   : 3-bit encodings of the boot FSM
//   BOOT_WE_*       : ram_we codes for word / half / byte stores (0 = read)
//   BOOT_*_BASE     : default ROM source and RAM destination byte offsets
package boot_loader_pkg;
    typedef enum logic [2:0] {
        BOOT_IDLE = 3'd0,
        BOOT_CRD  = 3'd1,
        BOOT_CWR  = 3'd2,
        BOOT_VRD  = 3'd3,
        BOOT_VCMP = 3'd4,
        BOOT_DONE = 3'd5,
        BOOT_ERR  = 3'd6
    } boot_state_e;
    localparam logic [2:0] BOOT_WE_WORD = 3'b110;
    localparam logic [2:0] BOOT_WE_HALF = 3'b101;
    localparam logic [2:0] BOOT_WE_BYTE = 3'b100;
    localparam int unsigned BOOT_SRC_BASE = 'h800;
    localparam int unsigned BOOT_DST_BASE = 'h000;
endpackage

// File: rtl/boot_addr_gen.sv
// boot_addr_gen: word index counter with terminal detection and ROM/RAM byte address generation.
//   clk, rst     : clock, asynchronous active-high reset
//   clr, inc     : reset index to 0 / advance index (clr wins)
//   last, empty  : index is on the final word / image has no words
//   src_n, dst_n : ROM / RAM byte addresses of the index value being loaded this cycle
module boot_addr_gen
    import boot_loader_pkg::*;
#(
    parameter int          AWIDTH     = 12,
    parameter int          XLEN       = 32,
    parameter int unsigned SRC_BASE   = BOOT_SRC_BASE,
    parameter int unsigned DST_BASE   = BOOT_DST_BASE,
    parameter int unsigned COPY_BYTES = 'h800
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              inc,
    output logic              last,
    output logic              empty,
    output logic [AWIDTH-1:0] src_n,
    output logic [AWIDTH-1:0] dst_n
);
    localparam int unsigned STRIDE = XLEN / 8;
    localparam int unsigned NW     = COPY_BYTES / STRIDE;

    logic [AWIDTH-1:0] idx_q, idx_d;

    // Addresses follow the next index so the FSM can register them on entry to a state;
    // truncation to AWIDTH makes wrap-around silent.
    always_comb begin
        idx_d = clr ? '0 : inc ? idx_q + AWIDTH'(1) : idx_q;
        src_n = AWIDTH'(SRC_BASE + 32'(idx_d) * STRIDE);
        dst_n = AWIDTH'(DST_BASE + 32'(idx_d) * STRIDE);
    end

    assign last  = idx_q == AWIDTH'(NW - 1);
    assign empty = NW == 0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) idx_q <= '0;
        else     idx_q <= idx_d;
    end
endmodule

// File: rtl/boot_loader.sv
// boot_loader: copies an image from ROM to RAM, optionally verifies it by readback, then releases the core.
//   clk, rst             : clock, asynchronous active-high reset
//   start                : one-cycle (re)run request, honoured only in IDLE/DONE/ERR
//   rom_addr / rom_data  : ROM byte address out, registered read data in (1 cycle latency)
//   ram_addr / ram_wdata / ram_we / ram_rdata : RAM port owned while core_hold=1
//   core_hold            : holds the core; stays set after a verify failure
//   busy, done, error    : copy/verify running, sticky success, sticky mismatch
//   err_addr             : RAM byte address of the first mismatching word
module boot_loader
    import boot_loader_pkg::*;
#(
    parameter int          AWIDTH     = 12,
    parameter int          XLEN       = 32,
    parameter int unsigned SRC_BASE   = BOOT_SRC_BASE,
    parameter int unsigned DST_BASE   = BOOT_DST_BASE,
    parameter int unsigned COPY_BYTES = 'h800,
    parameter logic [2:0]  WE_WORD    = BOOT_WE_WORD,
    parameter bit          VERIFY     = 1'b1,
    parameter bit          AUTO_START = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic [AWIDTH-1:0] rom_addr,
    input  logic [XLEN-1:0]   rom_data,
    output logic [AWIDTH-1:0] ram_addr,
    output logic [XLEN-1:0]   ram_wdata,
    output logic [2:0]        ram_we,
    input  logic [XLEN-1:0]   ram_rdata,
    output logic              core_hold,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic [AWIDTH-1:0] err_addr
);
    boot_state_e       state_q, state_d;
    logic [AWIDTH-1:0] rom_addr_q, rom_addr_d, ram_addr_q, ram_addr_d, err_addr_q, err_addr_d;
    logic [XLEN-1:0]   wdata_q, wdata_d;
    logic [2:0]        we_q, we_d;
    logic              busy_q, busy_d, done_q, done_d, error_q, error_d, core_hold_q, core_hold_d;
    logic              clr, inc, last, empty, launch, finish;
    logic [AWIDTH-1:0] src_n, dst_n;

    boot_addr_gen #(
        .AWIDTH(AWIDTH), .XLEN(XLEN), .SRC_BASE(SRC_BASE), .DST_BASE(DST_BASE), .COPY_BYTES(COPY_BYTES)
    ) u_addr (
        .clk(clk), .rst(rst), .clr(clr), .inc(inc), .last(last), .empty(empty), .src_n(src_n), .dst_n(dst_n)
    );

    always_comb begin
        state_d     = state_q;
        rom_addr_d  = rom_addr_q;
        ram_addr_d  = ram_addr_q;
        err_addr_d  = err_addr_q;
        wdata_d     = wdata_q;
        we_d        = 3'b000;
        busy_d      = busy_q;
        done_d      = done_q;
        error_d     = error_q;
        core_hold_d = core_hold_q;
        clr         = 1'b0;
        inc         = 1'b0;
        launch      = 1'b0;
        finish      = 1'b0;
        case (state_q)
            // IDLE is only reachable from reset, so core_hold_q here means an auto-start is pending
            BOOT_IDLE: launch = start | core_hold_q;
            BOOT_CRD: begin
                state_d    = BOOT_CWR;
                ram_addr_d = dst_n;
                we_d       = WE_WORD;
            end
            BOOT_CWR: begin
                wdata_d = rom_data;
                clr     = last;
                inc     = !last;
                if (!last) begin
                    state_d    = BOOT_CRD;
                    rom_addr_d = src_n;
                end else if (VERIFY) begin
                    state_d    = BOOT_VRD;
                    rom_addr_d = src_n;
                    ram_addr_d = dst_n;
                end else begin
                    finish = 1'b1;
                end
            end
            BOOT_VRD: state_d = BOOT_VCMP;
            BOOT_VCMP: begin
                if (ram_rdata != rom_data) begin
                    state_d    = BOOT_ERR;
                    err_addr_d = ram_addr_q;
                    error_d    = 1'b1;
                    busy_d     = 1'b0;
                end else if (last) begin
                    finish = 1'b1;
                end else begin
                    inc        = 1'b1;
                    state_d    = BOOT_VRD;
                    rom_addr_d = src_n;
                    ram_addr_d = dst_n;
                end
            end
            default: launch = start;
        endcase
        if (launch) begin
            clr         = 1'b1;
            busy_d      = 1'b1;
            core_hold_d = 1'b1;
            done_d      = 1'b0;
            error_d     = 1'b0;
            state_d     = BOOT_CRD;
            rom_addr_d  = empty ? rom_addr_q : src_n;
        end
        if (finish | (launch & empty)) begin
            state_d     = BOOT_DONE;
            busy_d      = 1'b0;
            done_d      = 1'b1;
            core_hold_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= BOOT_IDLE;
            rom_addr_q  <= '0;
            ram_addr_q  <= '0;
            err_addr_q  <= '0;
            wdata_q     <= '0;
            we_q        <= 3'b000;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            error_q     <= 1'b0;
            core_hold_q <= AUTO_START;
        end else begin
            state_q     <= state_d;
            rom_addr_q  <= rom_addr_d;
            ram_addr_q  <= ram_addr_d;
            err_addr_q  <= err_addr_d;
            wdata_q     <= wdata_d;
            we_q        <= we_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            error_q     <= error_d;
            core_hold_q <= core_hold_d;
        end
    end

    // ROM data is only valid during CWR, so the store passes it straight through and the
    // register keeps the last written word visible afterwards.
    assign ram_wdata = (state_q == BOOT_CWR) ? rom_data : wdata_q;
    assign rom_addr  = rom_addr_q;
    assign ram_addr  = ram_addr_q;
    assign ram_we    = we_q;
    assign err_addr  = err_addr_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign error     = error_q;
    assign core_hold = core_hold_q;
endmodule

// File: tb/tb_boot_loader.sv
// tb_boot_loader: four boot_loader configurations against ROM/RAM models and an expected write list.
module tb_boot_loader;
    typedef struct {
        int          cyc;
        logic [2:0]  we;
        logic [11:0] a;
        logic [31:0] d;
    } wr_t;

    logic clk = 1'b0, rst = 1'b1, corrupt = 1'b0;
    logic [3:0] start = '0;
    logic [3:0] core_hold, busy, done, error;
    logic [3:0][11:0] rom_addr, ram_addr, err_addr;
    logic [3:0][31:0] rom_data, ram_rdata, ram_wdata;
    logic [3:0][2:0] ram_we;
    logic [31:0] rom [1024];
    logic [31:0] ram [4][1024];
    wr_t wlog [4][$];
    int cyc = 0, passed = 0, total = 0;
    int unsigned dst_t [4] = '{'h000, 'h100, 'h000, 'hFF8};

    always #5 clk = ~clk;

    // 0: defaults  1: manual start, no verify, 16 words  2: empty image  3: wrapping destination
    for (genvar g = 0; g < 4; g++) begin : g_dut
        boot_loader #(
            .SRC_BASE('h800),
            .DST_BASE(g == 1 ? 'h100 : g == 3 ? 'hFF8 : 0),
            .COPY_BYTES(g == 1 ? 'h40 : g == 2 ? 0 : g == 3 ? 16 : 'h800),
            .VERIFY(g != 1),
            .AUTO_START(g != 1)
        ) dut (
            .clk(clk), .rst(rst), .start(start[g]),
            .rom_addr(rom_addr[g]), .rom_data(rom_data[g]),
            .ram_addr(ram_addr[g]), .ram_wdata(ram_wdata[g]), .ram_we(ram_we[g]), .ram_rdata(ram_rdata[g]),
            .core_hold(core_hold[g]), .busy(busy[g]), .done(done[g]), .error(error[g]), .err_addr(err_addr[g])
        );
    end

    always @(posedge clk) begin
        cyc <= cyc + 1;
        for (int i = 0; i < 4; i++) begin
            rom_data[i]  <= rom[rom_addr[i][11:2]];
            ram_rdata[i] <= ram[i][ram_addr[i][11:2]];
            if (ram_we[i] != 3'b000) begin
                ram[i][ram_addr[i][11:2]] <= (corrupt && i == 0 && ram_addr[i] == 12'h010) ? ram_wdata[i] ^ 32'h1 : ram_wdata[i];
                wlog[i].push_back(wr_t'{cyc, ram_we[i], ram_addr[i], ram_wdata[i]});
            end
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic wait_flag(input int i, input int lim, output int at);
        at = -1;
        for (int n = 0; n < lim && at < 0; n++) begin
            @(negedge clk);
            if (done[i] || error[i]) at = cyc;
        end
    endtask

    // Word k of every image comes from ROM byte 0x800+4k and lands at dst+4k (mod 4096), one store every 2 cycles.
    task automatic check_writes(input int i, input int from, input int n, input string tag);
        int bad = 0;
        for (int k = 0; k < n; k++) begin
            wr_t w;
            if (from + k >= wlog[i].size()) bad++;
            else begin
                w = wlog[i][from + k];
                if (w.we !== 3'b110 || w.a !== 12'(dst_t[i] + 4 * k) || w.d !== rom[10'((32'h800 + 4 * k) >> 2)]) bad++;
                if (k > 0 && w.cyc - wlog[i][from + k - 1].cyc != 2) bad++;
            end
        end
        chk({tag, "_cnt"}, 64'(wlog[i].size() - from), 64'(n));
        chk({tag, "_seq"}, 64'(bad), 0);
    endtask

    initial begin
        int rel, at, b0, b1, b3, bad;
        foreach (rom[k]) rom[k] = $urandom();
        repeat (3) @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            chk("rst_addr", {rom_addr[i], ram_addr[i], err_addr[i], ram_we[i]}, 0);
            chk("rst_wdata", ram_wdata[i], 0);
            chk("rst_flags", {busy[i], done[i], error[i], core_hold[i]}, {3'b000, i != 1});
        end
        rst = 1'b0;
        repeat (100) @(negedge clk);
        chk("pre_abort_busy", {busy[0], core_hold[0]}, 2'b11);
        #2 rst = 1'b1;
        #1;
        chk("abort_addr", {rom_addr[0], ram_addr[0], err_addr[0], ram_we[0]}, 0);
        chk("abort_flags", {busy[0], done[0], error[0], core_hold[0]}, 4'b0001);
        check_writes(0, 0, 49, "abort_wr");
        repeat (5) @(negedge clk);
        chk("abort_nowr", 64'(wlog[0].size()), 49);
        b0 = wlog[0].size();
        b1 = wlog[1].size();
        b3 = wlog[3].size();
        rel = cyc;
        rst = 1'b0;
        @(negedge clk);
        chk("empty_done", {busy[2], done[2], core_hold[2]}, 3'b010);
        chk("auto_hold", {busy[0], core_hold[0]}, 2'b11);
        chk("manual_idle", {busy[1], core_hold[1]}, 2'b00);
        wait_flag(0, 3000, at);
        chk("copy_latency", 64'(at - rel), 2049);
        chk("copy_flags", {busy[0], done[0], error[0], core_hold[0]}, 4'b0100);
        check_writes(0, b0, 512, "copy_wr");
        bad = 0;
        for (int k = 0; k < 512; k++) if (ram[0][k] !== rom[512 + k]) bad++;
        chk("ram_image", 64'(bad), 0);
        chk("wrap_flags", {done[3], error[3], core_hold[3]}, 3'b100);
        check_writes(3, b3, 4, "wrap_wr");
        chk("empty_nowr", 64'(wlog[2].size()), 0);
        chk("manual_still_idle", {busy[1], core_hold[1], done[1]}, 0);
        rel = cyc;
        start[1] = 1'b1;
        @(negedge clk);
        start[1] = 1'b0;
        chk("start_hold", {busy[1], core_hold[1]}, 2'b11);
        repeat ($urandom_range(3, 20)) @(negedge clk);
        start[1] = 1'b1;
        @(negedge clk);
        start[1] = 1'b0;
        wait_flag(1, 200, at);
        chk("manual_latency", 64'(at - rel), 2 * 16 + 1);
        chk("manual_flags", {busy[1], done[1], core_hold[1]}, 3'b010);
        repeat (4) @(negedge clk);
        check_writes(1, b1, 16, "manual_wr");
        corrupt = 1'b1;
        b0 = wlog[0].size();
        start[0] = 1'b1;
        @(negedge clk);
        start[0] = 1'b0;
        chk("rerun_flags", {busy[0], done[0], core_hold[0]}, 3'b101);
        wait_flag(0, 3000, at);
        chk("err_flags", {busy[0], done[0], error[0], core_hold[0]}, 4'b0011);
        chk("err_addr", err_addr[0], 12'h010);
        repeat (5) @(negedge clk);
        chk("err_hold", {core_hold[0], 32'(wlog[0].size() - b0)}, {1'b1, 32'd512});
        corrupt = 1'b0;
        start[0] = 1'b1;
        @(negedge clk);
        start[0] = 1'b0;
        chk("retry_clear", {busy[0], error[0]}, 2'b10);
        wait_flag(0, 3000, at);
        chk("retry_flags", {busy[0], done[0], error[0], core_hold[0]}, 4'b0100);
        chk("retry_word", ram[0][4], rom[516]);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
